// File: rtl/evm_vote_input_conditioner.sv
// Button conditioner for the EVM core: sync, debounce, edge-detect, one vote per arming.
// Optional ARMED dwell timeout is enabled by defining EVM_VOTE_TIMEOUT_EN.
module evm_vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_candidate,
    input  logic       btn_ready,
    input  logic       session_open,
    output logic       vote_candidate_1,
    output logic       vote_candidate_2,
    output logic       vote_candidate_3,
    output logic       candidate_ready,
    output logic       armed,
    output logic       conflict,
    output logic       timeout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ARMED, RELEASE} state_t;

    logic [3:0]    raw;
    logic [3:0]    s1_q, s2_q;
    logic [3:0]    stable_q, stable_dly_q;
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    press;
    logic [2:0]    cand_press;
    logic          ready_press;
    logic          single_press;
    logic          others_low;

    state_t     state_q, state_d;
    logic [2:0] vote_q, vote_d;
    logic       ready_q, ready_d;
    logic       conflict_q, conflict_d;

    assign raw = {btn_ready, btn_candidate};

    // Bit 3 is the ready button, bits 2:0 the candidates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q         <= raw;
            s2_q         <= s1_q;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (s2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_q[i] <= s2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press        = stable_q & ~stable_dly_q;
    assign cand_press   = press[2:0];
    assign ready_press  = press[3];
    assign single_press = (cand_press != 3'b000) &&
                          ((cand_press & (cand_press - 3'd1)) == 3'b000);
    assign others_low   = (stable_q[2:0] & ~cand_press) == 3'b000;

`ifdef EVM_VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] dwell_q, dwell_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        vote_d     = 3'b000;
        ready_d    = 1'b0;
        conflict_d = 1'b0;
`ifdef EVM_VOTE_TIMEOUT_EN
        timeout_d  = 1'b0;
        dwell_d    = '0;
`endif
        if (!session_open) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ready_press) begin
                        state_d = ARMED;
                        ready_d = 1'b1;
                    end
                end
                ARMED: begin
                    if (single_press && others_low) begin
                        vote_d  = cand_press;
                        state_d = RELEASE;
                    end else if (cand_press != 3'b000) begin
                        conflict_d = 1'b1;
                    end
`ifdef EVM_VOTE_TIMEOUT_EN
                    // A vote landing in the expiry cycle takes precedence.
                    if (state_d == ARMED) begin
                        if (dwell_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_d  = 1'b1;
                            conflict_d = 1'b0;
                            state_d    = IDLE;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
`endif
                end
                RELEASE: begin
                    if (stable_q[2:0] == 3'b000) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vote_q     <= 3'b000;
            ready_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vote_q     <= vote_d;
            ready_q    <= ready_d;
            conflict_q <= conflict_d;
        end
    end

    assign vote_candidate_1 = vote_q[0];
    assign vote_candidate_2 = vote_q[1];
    assign vote_candidate_3 = vote_q[2];
    assign candidate_ready  = ready_q;
    assign conflict         = conflict_q;
    assign armed            = (state_q == ARMED);

endmodule

// File: tb/tb_evm_vote_input_conditioner.sv
// Scoreboard bench for evm_vote_input_conditioner (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=32).
module tb_evm_vote_input_conditioner;

    localparam int D = 4;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_candidate;
    logic       btn_ready;
    logic       session_open;
    logic       v1, v2, v3, c_ready, armed, conflict, timeout;

    evm_vote_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_candidate   (btn_candidate),
        .btn_ready       (btn_ready),
        .session_open    (session_open),
        .vote_candidate_1(v1),
        .vote_candidate_2(v2),
        .vote_candidate_3(v3),
        .candidate_ready (c_ready),
        .armed           (armed),
        .conflict        (conflict),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    // code bits: 0..2 votes, 3 ready, 4 conflict, 5 timeout
    typedef struct {
        int         edge_no;
        logic [5:0] code;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   ecnt  = 0;
    int   obs_cnt [6];
    int   last_ready_edge = -1;

    // Reference model state
    bit hist [4][$];
    bit syn  [4][$];
    bit st [4], st_prev [4];
    int mstate;
    int dwell;
    bit m_armed;

    always @(posedge clk) begin
        bit [3:0]   rawv;
        bit         pr [4];
        bit         ns [4];
        logic [5:0] code;
        int         n;
        int         which;
        ecnt++;
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                hist[b].delete();
                syn[b].delete();
                st[b] = 0;
                st_prev[b] = 0;
            end
            mstate = 0;
            dwell = 0;
            m_armed = 0;
        end else begin
            rawv = {btn_ready, btn_candidate};
            for (int b = 0; b < 4; b++) begin
                bit s;
                bit all_diff;
                pr[b] = st[b] && !st_prev[b];
                hist[b].push_back(rawv[b]);
                s = (hist[b].size() >= 3) ? hist[b][hist[b].size() - 3] : 1'b0;
                if (hist[b].size() > 4) void'(hist[b].pop_front());
                syn[b].push_back(s);
                if (syn[b].size() > D) void'(syn[b].pop_front());
                all_diff = (syn[b].size() == D);
                foreach (syn[b][k]) if (syn[b][k] == st[b]) all_diff = 0;
                ns[b] = all_diff ? !st[b] : st[b];
            end
            code = '0;
            if (!session_open) begin
                mstate = 0;
            end else if (mstate == 0) begin
                if (pr[3]) begin
                    code[3] = 1;
                    mstate = 1;
                    dwell = 0;
                end
            end else if (mstate == 1) begin
                n = pr[0] + pr[1] + pr[2];
                which = pr[1] ? 1 : (pr[2] ? 2 : 0);
                if (n == 1 && (st[0] + st[1] + st[2]) == 1) begin
                    code[which] = 1;
                    mstate = 2;
                end else if (n >= 1) begin
                    code[4] = 1;
                end
`ifdef EVM_VOTE_TIMEOUT_EN
                if (mstate == 1) begin
                    dwell++;
                    if (dwell == T) begin
                        code = '0;
                        code[5] = 1;
                        mstate = 0;
                    end
                end
`endif
            end else begin
                if (!st[0] && !st[1] && !st[2]) mstate = 0;
            end
            if (code != 0) expq.push_back('{ecnt, code});
            m_armed = (mstate == 1);
            for (int b = 0; b < 4; b++) begin
                st_prev[b] = st[b];
                st[b] = ns[b];
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t       e;
        if (!rst) begin
            obs = {timeout, conflict, c_ready, v3, v2, v1};
            tests++;
            if (armed !== m_armed) begin
                fails++;
                $display("FAIL armed edge=%0d got=%b want=%b", ecnt, armed, m_armed);
            end
            while (expq.size() > 0 && expq[0].edge_no < ecnt) begin
                e = expq.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse edge=%0d got=none want=%b", e.edge_no, e.code);
            end
            if (obs != 0) begin
                for (int i = 0; i < 6; i++) if (obs[i]) obs_cnt[i]++;
                if (obs[3]) last_ready_edge = ecnt;
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse edge=%0d got=%b want=none", ecnt, obs);
                end else begin
                    e = expq.pop_front();
                    if (e.edge_no != ecnt || e.code != obs) begin
                        fails++;
                        $display("FAIL pulse edge=%0d got=%b want=%b@%0d",
                                 ecnt, obs, e.code, e.edge_no);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic press(input logic rdy, input logic [2:0] cand, input int hold);
        btn_ready = rdy;
        btn_candidate = cand;
        tick(hold);
        btn_ready = 0;
        btn_candidate = 0;
        tick(10);
    endtask

    int n_edge;
    int base;

    initial begin
        for (int i = 0; i < 6; i++) obs_cnt[i] = 0;
        rst = 1;
        btn_candidate = 0;
        btn_ready = 0;
        session_open = 0;
        #2;
        for (int i = 0; i < 6; i++) begin
            btn_candidate = 3'($urandom);
            btn_ready = 1'($urandom);
            tick(1);
            check("reset_outs", {v1, v2, v3, c_ready, armed, conflict, timeout}, 0);
        end
        btn_candidate = 0;
        btn_ready = 0;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_outs", {v1, v2, v3, c_ready, armed, conflict, timeout}, 0);
        end

        // Latency and a basic vote
        session_open = 1;
        btn_ready = 1;
        n_edge = ecnt + 1;
        tick(10);
        check("ready_latency", last_ready_edge, n_edge + 6);
        check("armed_after_ready", armed, 1);
        btn_ready = 0;
        tick(10);
        base = obs_cnt[1];
        press(0, 3'b010, 10);
        check("vote2_count", obs_cnt[1] - base, 1);
        check("armed_after_vote", armed, 0);

        // Bounce then hold, then a second press without re-arming
        press(1, 3'b000, 10);
        base = obs_cnt[0];
        for (int i = 0; i < 10; i++) begin
            btn_candidate = 3'b001;
            tick(2);
            btn_candidate = 3'b000;
            tick(2);
        end
        btn_candidate = 3'b001;
        tick(12);
        btn_candidate = 0;
        tick(10);
        press(0, 3'b001, 10);
        check("bounce_one_vote", obs_cnt[0] - base, 1);

        // Conflict, then a clean vote
        press(1, 3'b000, 10);
        base = obs_cnt[4];
        press(0, 3'b101, 10);
        check("conflict_count", obs_cnt[4] - base, 1);
        check("armed_after_conflict", armed, 1);
        base = obs_cnt[2];
        press(0, 3'b100, 10);
        check("vote3_count", obs_cnt[2] - base, 1);

        // Session gate
        press(1, 3'b000, 10);
        session_open = 0;
        tick(1);
        session_open = 1;
        tick(1);
        check("armed_gated", armed, 0);
        base = obs_cnt[0] + obs_cnt[1] + obs_cnt[2];
        press(0, 3'b001, 10);
        check("gated_no_vote", obs_cnt[0] + obs_cnt[1] + obs_cnt[2] - base, 0);

`ifdef EVM_VOTE_TIMEOUT_EN
        base = obs_cnt[5];
        press(1, 3'b000, 40);
        check("timeout_count", obs_cnt[5] - base, 1);
`endif

        // Randomised levels, bounce and occasional session drops
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) btn_ready = ~btn_ready;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 11) == 0) btn_candidate[b] = ~btn_candidate[b];
            session_open = ($urandom_range(0, 99) != 0);
            tick(1);
        end
        btn_candidate = 0;
        btn_ready = 0;
        session_open = 1;
        tick(20);
        check("queue_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
